button_debouncer: RTL

Debounces a bank of raw push-button inputs using the slow `clk_debounce` square wave as its sampling timebase. It consumes that wave as a plain level input inside the `clk_in` domain. For each button it produces a clean level, a one-cycle press pulse and a one-cycle release pulse. These outputs feed the game-control logic.

---
 rtl/button_debouncer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN push buttons, sampling them on rising edges of the slow clk_debounce wave.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.

module button_debouncer #(
    parameter int NUM_BTN        = 5,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_PERIOD  = 50
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               clk_debounce,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    // Out-of-range parameters leave a g_param_error scope in the elaborated hierarchy.
    if (STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_error
    end

    logic               r_dbc_s1;
    logic               r_dbc_s2;
    logic               r_dbc_d;
    logic               r_strobe;
    logic [NUM_BTN-1:0] r_btn_s1;
    logic [NUM_BTN-1:0] r_btn_s2;
    logic [CNT_W-1:0]   r_cnt [NUM_BTN];
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [NUM_BTN-1:0] w_level_nxt;
    logic [NUM_BTN-1:0] w_accept_press;
    logic [NUM_BTN-1:0] w_accept_release;
    logic [NUM_BTN-1:0] w_press_nxt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_dbc_s1 <= 1'b0;
            r_dbc_s2 <= 1'b0;
            r_dbc_d  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_dbc_s1 <= clk_debounce;
            r_dbc_s2 <= r_dbc_s1;
            r_dbc_d  <= r_dbc_s2;
            r_strobe <= r_dbc_s2 & ~r_dbc_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_btn_s1 <= btn_in;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // A sample agreeing with the current level restarts the count, so glitches never accumulate.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_level_nxt      = r_level;
        w_accept_press   = '0;
        w_accept_release = '0;
        if (r_strobe) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_btn_s2[i] == r_level[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_cnt_nxt[i]        = '0;
                    w_level_nxt[i]      = r_btn_s2[i];
                    w_accept_press[i]   = r_btn_s2[i];
                    w_accept_release[i] = ~r_btn_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0]   r_rpt [NUM_BTN];
    logic [RPT_W-1:0]   w_rpt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] r_phase;
    logic [NUM_BTN-1:0] w_phase_nxt;
    logic [NUM_BTN-1:0] w_repeat;

    // An accepted edge in the same strobe wins over a due repeat pulse.
    always_comb begin
        w_rpt_nxt   = r_rpt;
        w_phase_nxt = r_phase;
        w_repeat    = '0;
        if (r_strobe) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_accept_press[i] || w_accept_release[i]) begin
                    w_rpt_nxt[i]   = '0;
                    w_phase_nxt[i] = 1'b0;
                end else if (r_level[i]) begin
                    if ((r_rpt[i] + RPT_W'(1)) == (r_phase[i] ? RPT_PERIOD_V : RPT_DELAY_V)) begin
                        w_rpt_nxt[i]   = '0;
                        w_phase_nxt[i] = 1'b1;
                        w_repeat[i]    = 1'b1;
                    end else begin
                        w_rpt_nxt[i] = r_rpt[i] + RPT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rpt[i] <= '0;
            end
            r_phase <= '0;
        end else begin
            r_rpt   <= w_rpt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign w_press_nxt = w_accept_press | w_repeat;
`else
    assign w_press_nxt = w_accept_press;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_accept_release;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule
